// File: rtl/timeout_arbiter_if.sv
// Bundle of timeout_arbiter signals. The requester side drives req/hold and
// observes grant/expiry status; the arbiter side is the counter owner.
interface timeout_arbiter_if #(
  parameter int NREQ = 4,
  parameter int CW   = 7,
  parameter int OW   = (NREQ > 1) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0] req;
  logic            hold;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] time_out;
  logic            busy;
  logic [OW-1:0]   owner;
  logic [CW-1:0]   count;

  modport master (
    output req, hold,
    input  grant, time_out, busy, owner, count
  );

  modport slave (
    input  req, hold,
    output grant, time_out, busy, owner, count
  );
endinterface

// File: rtl/timeout_arbiter.sv
// Shared timeout counter with round-robin ownership. One requester at a time
// owns the counter; it expires after TERM+1 counting cycles and pulses
// time_out to the owner. Dropping the owner's req cancels without a pulse.
// All outputs come straight from registers. CW must satisfy 2^CW-1 >= TERM.
module timeout_arbiter #(
  parameter int NREQ = 4,
  parameter int TERM = 100,
  parameter int CW   = 7
) (
  input  logic          clk,
  input  logic          reset,
  timeout_arbiter_if.slave bus
);
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  localparam logic [OW-1:0] OWNER_RST = OW'(NREQ - 1);
  localparam logic [CW-1:0] TERM_C    = CW'(TERM);

  logic [1:0]      state_r, state_s;
  logic [NREQ-1:0] grant_r, grant_s;
  logic [NREQ-1:0] time_out_r, time_out_s;
  logic [CW-1:0]   count_r, count_s;
  logic [OW-1:0]   owner_r, owner_s;
  logic            busy_r, busy_s;

  logic [OW-1:0]   win_idx_s;
  logic            win_found_s;
  logic [OW:0]     cand_s;

  // Round-robin search: start just after the last owner, first high req wins.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = owner_r;
    cand_s      = {1'b0, owner_r};
    for (int i = 1; i <= NREQ; i++) begin
      cand_s = {1'b0, owner_r} + (OW+1)'(i);
      cand_s = (cand_s >= (OW+1)'(NREQ)) ? (cand_s - (OW+1)'(NREQ)) : cand_s;
      if (!win_found_s && bus.req[cand_s[OW-1:0]]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s[OW-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Next-state and next-output computation for the IDLE/RUN/DONE machine.
  always_comb begin
    state_s    = state_r;
    grant_s    = grant_r;
    time_out_s = {NREQ{1'b0}};
    count_s    = count_r;
    owner_s    = owner_r;
    case (state_r)
      IDLE: begin
        grant_s = {NREQ{1'b0}};
        count_s = {CW{1'b0}};
        if (win_found_s) begin
          state_s = RUN;
          grant_s = NREQ'(1'b1) << win_idx_s;
          owner_s = win_idx_s;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (!bus.req[owner_r]) begin
          // Cancel beats both hold and expiry: no pulse is ever issued.
          state_s = IDLE;
          grant_s = {NREQ{1'b0}};
          count_s = {CW{1'b0}};
        end else if (bus.hold) begin
          state_s = RUN;
        end else if (count_r >= TERM_C) begin
          // Greater-than also expires so a corrupted count cannot run away.
          state_s    = DONE;
          time_out_s = grant_r;
          grant_s    = {NREQ{1'b0}};
          count_s    = {CW{1'b0}};
        end else begin
          count_s = count_r + CW'(1);
        end
      end
      DONE: begin
        state_s = IDLE;
        grant_s = {NREQ{1'b0}};
        count_s = {CW{1'b0}};
      end
      default: begin
        state_s = IDLE;
        grant_s = {NREQ{1'b0}};
        count_s = {CW{1'b0}};
        owner_s = OWNER_RST;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= IDLE;
      grant_r    <= {NREQ{1'b0}};
      time_out_r <= {NREQ{1'b0}};
      count_r    <= {CW{1'b0}};
      owner_r    <= OWNER_RST;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      grant_r    <= grant_s;
      time_out_r <= time_out_s;
      count_r    <= count_s;
      owner_r    <= owner_s;
      busy_r     <= busy_s;
    end
  end

  assign bus.grant    = grant_r;
  assign bus.time_out = time_out_r;
  assign bus.count    = count_r;
  assign bus.owner    = owner_r;
  assign bus.busy     = busy_r;

endmodule

// File: tb/tb_timeout_arbiter.sv
// Directed bench for timeout_arbiter (NREQ=4, TERM=100, CW=7).
module tb_timeout_arbiter;
  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  timeout_arbiter_if #(.NREQ(4), .CW(7)) bus ();

  timeout_arbiter #(.NREQ(4), .TERM(100), .CW(7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic [3:0] t,
                            input logic [6:0] c, input logic b);
    chk({tag, ".grant"},    32'(bus.grant),    32'(g));
    chk({tag, ".time_out"}, 32'(bus.time_out), 32'(t));
    chk({tag, ".count"},    32'(bus.count),    32'(c));
    chk({tag, ".busy"},     32'(bus.busy),     32'(b));
    chk({tag, ".grant1h"},  32'($onehot0(bus.grant)),    32'd1);
    chk({tag, ".to1h"},     32'($onehot0(bus.time_out)), 32'd1);
  endtask

  initial begin
    logic [3:0] eg;
    clk         = 1'b0;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    bus.req     = 4'b0000;
    bus.hold    = 1'b0;
    tick(2);
    expect_out("reset", 4'b0000, 4'b0000, 7'd0, 1'b0);
    chk("reset.owner", 32'(bus.owner), 32'd3);
    reset = 1'b1;

    // Single requester, full latency.
    bus.req = 4'b0001;
    tick(1);
    expect_out("single.G", 4'b0001, 4'b0000, 7'd0, 1'b1);
    chk("single.owner", 32'(bus.owner), 32'd0);
    tick(100);
    expect_out("single.G100", 4'b0001, 4'b0000, 7'd100, 1'b1);
    tick(1);
    expect_out("single.G101", 4'b0000, 4'b0001, 7'd0, 1'b1);
    tick(1);
    expect_out("single.G102", 4'b0000, 4'b0000, 7'd0, 1'b0);
    bus.req = 4'b0000;
    tick(1);
    expect_out("single.idle", 4'b0000, 4'b0000, 7'd0, 1'b0);

    // Contention from a fresh reset: strict rotation 0,1,2,3,0.
    reset = 1'b0;
    tick(1);
    reset   = 1'b1;
    bus.req = 4'b1111;
    tick(1);
    for (int k = 0; k < 5; k++) begin
      eg = 4'b0001 << (k % 4);
      expect_out("cont.grant", eg, 4'b0000, 7'd0, 1'b1);
      tick(100);
      expect_out("cont.cnt", eg, 4'b0000, 7'd100, 1'b1);
      tick(1);
      expect_out("cont.to", 4'b0000, eg, 7'd0, 1'b1);
      if (k == 4) bus.req = 4'b0000;
      tick(1);
      expect_out("cont.idle", 4'b0000, 4'b0000, 7'd0, 1'b0);
      if (k < 4) tick(1);
    end

    // Hold for 20 cycles at count 50; old owner wins again when alone.
    bus.req = 4'b0001;
    tick(1);
    expect_out("hold.G", 4'b0001, 4'b0000, 7'd0, 1'b1);
    tick(50);
    expect_out("hold.c50", 4'b0001, 4'b0000, 7'd50, 1'b1);
    bus.hold = 1'b1;
    tick(20);
    expect_out("hold.held", 4'b0001, 4'b0000, 7'd50, 1'b1);
    bus.hold = 1'b0;
    tick(50);
    expect_out("hold.G120", 4'b0001, 4'b0000, 7'd100, 1'b1);
    tick(1);
    expect_out("hold.G121", 4'b0000, 4'b0001, 7'd0, 1'b1);
    bus.req = 4'b0000;
    tick(1);
    expect_out("hold.idle", 4'b0000, 4'b0000, 7'd0, 1'b0);

    // Cancel at count 30, next requester granted after.
    bus.req = 4'b0011;
    tick(1);
    expect_out("cancel.G", 4'b0010, 4'b0000, 7'd0, 1'b1);
    chk("cancel.owner", 32'(bus.owner), 32'd1);
    tick(30);
    expect_out("cancel.c30", 4'b0010, 4'b0000, 7'd30, 1'b1);
    bus.req = 4'b0001;
    tick(1);
    expect_out("cancel.drop", 4'b0000, 4'b0000, 7'd0, 1'b0);
    tick(1);
    expect_out("cancel.next", 4'b0001, 4'b0000, 7'd0, 1'b1);
    chk("cancel.owner2", 32'(bus.owner), 32'd0);
    bus.req = 4'b0000;
    tick(1);
    expect_out("cancel.idle", 4'b0000, 4'b0000, 7'd0, 1'b0);

    // Cancel in the terminal-count cycle: no pulse.
    bus.req = 4'b0001;
    tick(101);
    expect_out("race.c100", 4'b0001, 4'b0000, 7'd100, 1'b1);
    bus.req = 4'b0000;
    tick(1);
    expect_out("race.cancel", 4'b0000, 4'b0000, 7'd0, 1'b0);
    tick(1);
    expect_out("race.quiet", 4'b0000, 4'b0000, 7'd0, 1'b0);

    // Hold in the terminal-count cycle defers expiry.
    bus.req = 4'b0001;
    tick(101);
    expect_out("rhold.c100", 4'b0001, 4'b0000, 7'd100, 1'b1);
    bus.hold = 1'b1;
    tick(3);
    expect_out("rhold.held", 4'b0001, 4'b0000, 7'd100, 1'b1);
    bus.hold = 1'b0;
    tick(1);
    expect_out("rhold.to", 4'b0000, 4'b0001, 7'd0, 1'b1);
    bus.req = 4'b0000;
    tick(1);
    expect_out("rhold.idle", 4'b0000, 4'b0000, 7'd0, 1'b0);

    // Cancel takes precedence over hold.
    bus.req = 4'b0001;
    tick(11);
    expect_out("chold.c10", 4'b0001, 4'b0000, 7'd10, 1'b1);
    bus.hold = 1'b1;
    bus.req  = 4'b0000;
    tick(1);
    expect_out("chold.cancel", 4'b0000, 4'b0000, 7'd0, 1'b0);
    bus.hold = 1'b0;

    // Reset mid-run at count 70; first grant afterwards is lowest index.
    bus.req = 4'b0010;
    tick(1);
    expect_out("rst.G", 4'b0010, 4'b0000, 7'd0, 1'b1);
    chk("rst.owner1", 32'(bus.owner), 32'd1);
    tick(70);
    expect_out("rst.c70", 4'b0010, 4'b0000, 7'd70, 1'b1);
    reset = 1'b0;
    tick(1);
    expect_out("rst.abort", 4'b0000, 4'b0000, 7'd0, 1'b0);
    chk("rst.owner", 32'(bus.owner), 32'd3);
    bus.req = 4'b0110;
    reset   = 1'b1;
    tick(1);
    expect_out("rst.regrant", 4'b0010, 4'b0000, 7'd0, 1'b1);
    chk("rst.owner2", 32'(bus.owner), 32'd1);
    tick(1);
    expect_out("rst.count1", 4'b0010, 4'b0000, 7'd1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
